draw_sequencer: RTL
===================

Name: draw_sequencer

Overview:
- Command-side initiator for the rectangle pixel drawer (item/erase/position in; x/y/colour/plot out).
- Accepts "place item at position" commands from game logic over a valid/ready handshake.
- Sequences each command as: erase the item's previous rectangle (if one exists), then draw the new one.
- Frames each pass by holding the drawer in counter-reset for one cycle, then releasing it for exactly W*H cycles, so every pass starts at pixel (0,0) and covers each pixel once.

Parameters:
- PRESS_W, 40, press rectangle width in pixels
- PRESS_H, 60, press rectangle height in pixels
- GARB_W, 20, garbage rectangle width in pixels
- GARB_H, 20, garbage rectangle height in pixels

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_item  in  1  1 = press, 0 = garbage
- cmd_position  in  3  target slot 0..7, passed through unchanged
- draw_item  out  1  to drawer item
- draw_erase  out  1  to drawer erase (1 = black)
- draw_position  out  3  to drawer position
- draw_run  out  1  to drawer reset_n (0 = hold counters at 0)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. On reset:
  - state = IDLE; prev_valid[press] = prev_valid[garb] = 0; prev_pos[*] = 0; span counter = 0.
  - Outputs: draw_run = 0, draw_erase = 0, draw_item = 0, draw_position = 0, busy = 0, done = 0.
  - cmd_ready = 1 from the first cycle after reset releases.
  - Reset mid-operation aborts the pass immediately. The partially drawn rectangle is left on screen and history is lost.
- Handshake:
  - Transfer occurs on a clk edge where cmd_valid && cmd_ready.
  - cmd_item and cmd_position are latched into new_item/new_pos on that edge.
  - cmd_ready = (state == IDLE), combinational from state.
  - Commands presented while busy are not accepted; the upstream block holds them.
- N = PRESS_W*PRESS_H (2400) if new_item = 1, else GARB_W*GARB_H (400).
- Counter width = $clog2(max N) = 12 bits. The counter counts 0..N-1 with no wrap beyond N-1.
- States:
  - IDLE: draw_run = 0. On accept, go to ERASE_ARM if prev_valid[new_item], else DRAW_ARM.
  - ERASE_ARM (1 cycle): draw_run = 0, draw_erase = 1, draw_item = new_item, draw_position = prev_pos[new_item]. Clear counter. Go to ERASE.
  - ERASE (N cycles): draw_run = 1; item, erase, position held. Counter increments; at N-1 go to DRAW_ARM.
  - DRAW_ARM (1 cycle): draw_run = 0, draw_erase = 0, draw_position = new_pos. Clear counter. Go to DRAW.
  - DRAW (N cycles): draw_run = 1; at N-1 go to FINISH.
  - FINISH (1 cycle): draw_run = 0, done = 1. Set prev_pos[new_item] = new_pos and prev_valid[new_item] = 1. Go to IDLE.
- Latency from the accept edge to done:
  - N+2 cycles without erase.
  - 2N+3 cycles with erase.
- draw_item, draw_erase and draw_position must be stable for the whole run window, including the arm cycle before it.
- Press and garbage histories are independent. Drawing a press never erases garbage.
- Same position as the previous one: still erase then redraw.
- Positions 4..7 are treated like any other value; the drawer defines their mapping.

Decomposition:
- Package draw_pkg holds:
  - state enum (IDLE, ERASE_ARM, ERASE, DRAW_ARM, DRAW, FINISH)
  - ITEM_PRESS = 1'b1, ITEM_GARB = 1'b0
  - geometry defaults and SPAN_W = 12
- One sub-module, span_timer: loadable up-counter with clear, enable, a limit input and a last output (count == limit-1).

Test Plan:
- Reset, then first press at pos 2, accepted at cycle 0 -> cycle 1: DRAW_ARM (draw_run = 0, erase = 0, pos = 2); cycles 2..2401: draw_run = 1; cycle 2402: done = 1; cycle 2403: cmd_ready = 1.
- Second press at pos 1 -> cycles 1..2401: erase pass (erase = 1, pos = 2); cycle 2402: DRAW_ARM pos 1; cycles 2403..4802: draw; cycle 4803: done.
- Garbage at pos 3 after presses exist -> no erase pass; 400-cycle draw; done at cycle 402; press history unchanged.
- cmd_valid held high during busy with a different command -> not accepted until IDLE, then accepted on the first IDLE edge; no command lost or duplicated.
- reset_n low at cycle 1000 of a press draw -> next cycle: state IDLE, draw_run = 0, busy = 0; the next press command runs with no erase pass.
- Back-to-back garbage at the same pos 0 -> erase pos 0 (400 cycles), then draw pos 0 (400 cycles); done at cycle 803.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw sequencer: FSM states, item codes,
// default rectangle geometry and the span counter width.
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_ARM,
    ERASE,
    DRAW_ARM,
    DRAW,
    FINISH
  } state_t;

  localparam logic ITEM_PRESS = 1'b1;
  localparam logic ITEM_GARB  = 1'b0;

  localparam int PRESS_W_DEF = 40;
  localparam int PRESS_H_DEF = 60;
  localparam int GARB_W_DEF  = 20;
  localparam int GARB_H_DEF  = 20;

  localparam int SPAN_W = 12;

  // Pixel count of one pass for the given item.
  function automatic logic [SPAN_W-1:0] span_len(input logic item,
                                                 input int pw, input int ph,
                                                 input int gw, input int gh);
    if (item == ITEM_PRESS) return SPAN_W'(pw * ph);
    else                    return SPAN_W'(gw * gh);
  endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Command handshake from game logic: transfer on a clk edge where
// cmd_valid && cmd_ready; the master holds item/position stable until then.
interface draw_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_item;
  logic [2:0] cmd_position;

  modport master (output cmd_valid, output cmd_item, output cmd_position,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_item, input  cmd_position,
                  output cmd_ready);
endinterface

// File: rtl/draw_sequencer_span_timer.sv
// Pass-length counter: clear to 0, count up while enabled, and stop at
// limit-1 where last is raised.
module span_timer
  import draw_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [SPAN_W-1:0] limit,
  output logic              last
);

  logic [SPAN_W-1:0] count;

  assign last = (count == limit - SPAN_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n)              count <= '0;
    else if (clear)            count <= '0;
    else if (enable && !last)  count <= count + SPAN_W'(1);
  end

endmodule

// File: rtl/draw_sequencer.sv
// Turns "place item at position" commands into framed drawer passes:
// erase the item's previous rectangle if one exists, then draw the new one.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int PRESS_W = PRESS_W_DEF,
  parameter int PRESS_H = PRESS_H_DEF,
  parameter int GARB_W  = GARB_W_DEF,
  parameter int GARB_H  = GARB_H_DEF
)(
  input  logic              clk,
  input  logic              reset_n,
  draw_sequencer_if.slave   cmd,
  output logic              draw_item,
  output logic              draw_erase,
  output logic [2:0]        draw_position,
  output logic              draw_run,
  output logic              busy,
  output logic              done,
  output state_t            state
);

  state_t      next_state;
  logic        new_item;
  logic [2:0]  new_pos;
  logic [1:0]  prev_valid;
  logic [2:0]  prev_pos [2];
  logic        span_clear;
  logic        span_enable;
  logic        span_last;
  logic [SPAN_W-1:0] span_limit;

  assign span_limit = span_len(new_item, PRESS_W, PRESS_H, GARB_W, GARB_H);

  span_timer u_span (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (span_clear),
    .enable  (span_enable),
    .limit   (span_limit),
    .last    (span_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state    = state;
    span_clear    = 1'b0;
    span_enable   = 1'b0;
    draw_item     = 1'b0;
    draw_erase    = 1'b0;
    draw_position = 3'd0;
    draw_run      = 1'b0;
    done          = 1'b0;
    cmd.cmd_ready = (state == IDLE);
    busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (cmd.cmd_valid)
          next_state = prev_valid[cmd.cmd_item] ? ERASE_ARM : DRAW_ARM;
      end
      ERASE_ARM: begin
        draw_erase    = 1'b1;
        draw_item     = new_item;
        draw_position = prev_pos[new_item];
        span_clear    = 1'b1;
        next_state    = ERASE;
      end
      ERASE: begin
        draw_run      = 1'b1;
        draw_erase    = 1'b1;
        draw_item     = new_item;
        draw_position = prev_pos[new_item];
        span_enable   = 1'b1;
        if (span_last) next_state = DRAW_ARM;
      end
      DRAW_ARM: begin
        draw_item     = new_item;
        draw_position = new_pos;
        span_clear    = 1'b1;
        next_state    = DRAW;
      end
      DRAW: begin
        draw_run      = 1'b1;
        draw_item     = new_item;
        draw_position = new_pos;
        span_enable   = 1'b1;
        if (span_last) next_state = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command latch and per-item history; history only advances on completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      new_item    <= 1'b0;
      new_pos     <= 3'd0;
      prev_valid  <= 2'b00;
      prev_pos[0] <= 3'd0;
      prev_pos[1] <= 3'd0;
    end else begin
      if (state == IDLE && cmd.cmd_valid) begin
        new_item <= cmd.cmd_item;
        new_pos  <= cmd.cmd_position;
      end
      if (state == FINISH) begin
        prev_valid[new_item] <= 1'b1;
        prev_pos[new_item]   <= new_pos;
      end
    end
  end

endmodule
